// File: rtl/aes256_key_schedule.sv
// AES-256 key expansion: writes rk0/rk1 from the cipher key, then derives rk2..rk14
// at one round key per cycle into a 15-entry register file with a registered read port.
module aes256_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int         NUM_RK   = 15;
  localparam logic [3:0] FIRST_RK = 4'd2;
  localparam logic [3:0] LAST_RK  = 4'd14;
  localparam logic [3:0] NULL_IDX = 4'd15;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Index is i/8 for the first word of an even round key, i.e. r/2.
  function automatic logic [7:0] rcon(input logic [2:0] n);
    case (n)
      3'd1:    return 8'h01;
      3'd2:    return 8'h02;
      3'd3:    return 8'h04;
      3'd4:    return 8'h08;
      3'd5:    return 8'h10;
      3'd6:    return 8'h20;
      3'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state;
  state_t         next_state;
  logic           load;
  logic           step;
  logic           finish;
  logic [3:0]     r;
  logic [127:0]   rk_mem [NUM_RK];
  logic [127:0]   prev_rk;
  logic [127:0]   older_rk;
  logic [31:0]    temp;
  logic [31:0]    w0;
  logic [31:0]    w1;
  logic [31:0]    w2;
  logic [31:0]    w3;
  logic [127:0]   next_rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (r == LAST_RK) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: blocking assignments here are deliberate: w1..w3 must see the freshly computed
  // word of the same cycle, which is how the three dependent words chain combinationally.
  always_comb begin
    prev_rk  = rk_mem[r - 4'd1];
    older_rk = rk_mem[r - 4'd2];
    if (r[0]) temp = sub_word(prev_rk[31:0]);
    else      temp = sub_word(rot_word(prev_rk[31:0])) ^ {rcon(r[3:1]), 24'h000000};
    w0      = older_rk[127:96] ^ temp;
    w1      = older_rk[95:64]  ^ w0;
    w2      = older_rk[63:32]  ^ w1;
    w3      = older_rk[31:0]   ^ w2;
    next_rk = {w0, w1, w2, w3};
  end

  // NOTE: the round-key registers are flops with an async clear, not a RAM, so reset
  // observably zeroes every entry rather than only the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r          <= 4'd0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rk_out     <= '0;
      for (int i = 0; i < NUM_RK; i++) rk_mem[i] <= '0;
    end else begin
      done   <= finish;
      rk_out <= (rk_idx == NULL_IDX) ? '0 : rk_mem[rk_idx];
      if (load) begin
        rk_mem[0]  <= key[255:128];
        rk_mem[1]  <= key[127:0];
        r          <= FIRST_RK;
        keys_valid <= 1'b0;
      end else if (step) begin
        rk_mem[r] <= next_rk;
        if (r != LAST_RK) r <= r + 4'd1;
      end
      if (finish) keys_valid <= 1'b1;
    end
  end

  assign busy = (state == EXPAND);

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Self-checking bench for aes256_key_schedule: independent FIPS-197 key expansion and
// inverse-cipher model, scoreboard of expected round keys, scenario tasks run in sequence.
module tb_aes256_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;
  logic         keys_valid;

  aes256_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox_t     [256];
  logic [7:0]   inv_sbox_t [256];
  logic [127:0] model_rk   [15];
  logic [127:0] dut_rk     [15];
  logic [127:0] exp_q      [$];

  localparam logic [255:0] FIPS_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] SP800_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] xb, inv, s;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[xb]    = s;
      inv_sbox_t[s] = xb;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_model(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = sub_word_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        temp = sub_word_m(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // AES-256 inverse cipher keyed by the round keys read back from the DUT.
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = ct[127 - 8*b -: 8] ^ dut_rk[14][127 - 8*b -: 8];
    for (int rnd = 13; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
      for (int b = 0; b < 16; b++) s[b] = inv_sbox_t[t[b]] ^ dut_rk[rnd][127 - 8*b -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
    end
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [255:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait; a missing done leaves lat at 40, which the callers flag.
  task automatic wait_done(input int from_cycle, output int lat);
    lat = from_cycle;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_all_rks(input string name);
    logic [127:0] exp;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(model_rk[i]);
      rk_idx = i[3:0];
      tick();
      exp = exp_q.pop_front();
      dut_rk[i] = rk_out;
      n_tests++;
      if (rk_out !== exp) begin
        n_fail++;
        $display("FAIL %s rk%0d: got %h expected %h", name, i, rk_out, exp);
      end
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rk_idx = idx;
    tick();
    n_tests++;
    if (rk_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, rk_out, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    n_tests++;
    if ({busy, done, keys_valid} !== 3'b000 || rk_out !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got busy/done/kv=%b rk_out=%h expected 000 and 0",
               {busy, done, keys_valid}, rk_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rk_idx = 4'd1;
    tick();
    n_tests++;
    if ({busy, done, keys_valid} !== 3'b000 || rk_out !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got busy/done/kv=%b rk_out=%h expected 000 and 0",
               {busy, done, keys_valid}, rk_out);
    end
  endtask

  task automatic test_fips_vector();
    int lat = 1;
    int busy_cnt = 0;
    expand_model(FIPS_KEY);
    pulse_start(FIPS_KEY);
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL fips_latency: got %0d expected 14", lat);
    end
    n_tests++;
    if (busy_cnt != 13 || busy !== 1'b0 || keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_flags: got busy_cycles=%0d busy=%b kv=%b expected 13 0 1",
               busy_cnt, busy, keys_valid);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_done_pulse: got done=%b expected 0", done);
    end
    read_rk(4'd2,  128'ha573c29fa176c498a97fce93a572c09c, "fips_rk2");
    read_rk(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "fips_rk14");
    check_all_rks("fips_model");
    n_tests++;
    if (inv_cipher(128'h8ea2b7ca516745bfeafc49904b496089) !== 128'h00112233445566778899aabbccddeeff) begin
      n_fail++;
      $display("FAIL fips_decipher: got %h expected 00112233445566778899aabbccddeeff",
               inv_cipher(128'h8ea2b7ca516745bfeafc49904b496089));
    end
  endtask

  task automatic test_sp800_vector();
    int lat;
    expand_model(SP800_KEY);
    pulse_start(SP800_KEY);
    wait_done(1, lat);
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL sp800_latency: got %0d expected 14", lat);
    end
    read_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "sp800_rk14");
    read_rk(4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "sp800_rk0");
    check_all_rks("sp800_model");
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [255:0] ka = rand_key();
    logic [255:0] kb = rand_key();
    pulse_start(ka);
    repeat (4) tick();
    key   = kb;
    start = 1'b1;
    tick();
    start = 1'b0;
    key   = '0;
    wait_done(6, lat);
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d expected 14", lat);
    end
    expand_model(ka);
    check_all_rks("busy_start_keeps_first_key");
  endtask

  task automatic test_reset_mid_expand();
    int lat;
    logic [255:0] ka = rand_key();
    logic [255:0] kb = rand_key() | 256'h1;
    rk_idx = 4'd0;
    pulse_start(ka);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, keys_valid} !== 3'b000 || rk_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy/done/kv=%b rk_out=%h expected 000 and 0",
               {busy, done, keys_valid}, rk_out);
    end
    tick();
    rst_n  = 1'b1;
    rk_idx = 4'd3;
    tick();
    n_tests++;
    if (rk_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_cleared: got rk3=%h busy=%b done=%b expected 0 0 0",
               rk_out, busy, done);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_start(kb);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release_edge_start: got busy=%b expected 1", busy);
    end
    wait_done(1, lat);
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL mid_reset_restart_latency: got %0d expected 14", lat);
    end
    expand_model(kb);
    read_rk(4'd14, model_rk[14], "mid_reset_restart_rk14");
  endtask

  task automatic test_idx15_restart();
    int lat;
    logic [255:0] kc = rand_key();
    read_rk(4'd15, 128'h0, "idx15_zero");
    expand_model(kc);
    pulse_start(kc);
    n_tests++;
    if (keys_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_flags: got kv=%b busy=%b expected 0 1", keys_valid, busy);
    end
    wait_done(1, lat);
    n_tests++;
    if (lat != 14 || keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: got latency=%0d kv=%b expected 14 1", lat, keys_valid);
    end
    read_rk(4'd14, model_rk[14], "restart_rk14");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [255:0] kd = rand_key();
    logic [255:0] ke = rand_key();
    pulse_start(kd);
    wait_done(1, lat);
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d expected 14", lat);
    end
    pulse_start(ke);
    n_tests++;
    if ({done, keys_valid, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_restart_flags: got done/kv/busy=%b expected 001", {done, keys_valid, busy});
    end
    wait_done(1, lat);
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d expected 14", lat);
    end
    expand_model(ke);
    check_all_rks("b2b_model");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_sp800_vector();
    test_start_while_busy();
    test_reset_mid_expand();
    test_idx15_restart();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
